tinyalu_core: RTL and testbench
===============================

Name: tinyalu_core

Overview:
Responder end of the tinyALU start/done operation protocol. This is the DUT-side block the BFM drives and the scoreboard checks.
- Accepts 8-bit operands and an opcode on a start request.
- Runs single-cycle ops (add/and/xor) or a multi-cycle pipelined multiply.
- Returns a 16-bit result with a one-cycle done pulse.

Parameters:
MUL_LATENCY, 3, edges from start sample to done for mul_op; legal range 2..8.
SINGLE_LATENCY, 1, edges from start sample to done for non-mul ops; fixed at 1 and not overridable.

Ports:
clk  input  1  single system clock; all state updates on its rising edge
reset_n  input  1  reset, asynchronous and active-low
A  input  8  operand A, unsigned
B  input  8  operand B, unsigned
op  input  3  opcode, tinyalu_pkg operation_t encoding
start  input  1  request; held high by requester until done is seen
done  output  1  registered one-cycle completion pulse
result  output  16  registered result, valid from the done cycle until the next completion

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, done=0, result=16'h0000, latency counter=0, mul pipeline cleared.
  - Any in-flight op is discarded; no done is pulsed after reset_n releases.
- Opcodes (tinyalu_pkg):
  - no_op=3'b000, add_op=3'b001, and_op=3'b010, xor_op=3'b011, mul_op=3'b100, rst_op=3'b111.
  - 3'b101 and 3'b110 are treated as no_op.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - start is sampled only here.
  - On the edge k where start=1: capture A, B, op into internal registers and go to BUSY.
  - Load the counter with L-1, where L=1 for non-mul ops and L=MUL_LATENCY for mul_op.
- BUSY:
  - Decrement the counter each edge.
  - At the edge where counter==0 (edge k+L): write result, assert done, go to DONE.
  - A/B/op/start changes during BUSY are ignored; only the captured values are used.
- DONE:
  - done is high for exactly this one cycle.
  - The next edge returns unconditionally to IDLE and deasserts done; start is ignored in DONE.
- Handshake:
  - The requester drops start during the done cycle.
  - If start is still high at the first IDLE edge (k+L+2), a new op begins with the A/B/op present then.
  - Maximum throughput is one op per L+2 cycles.
- Arithmetic (unsigned, zero-extended to 16 bits):
  - add: {7'b0, A+B (9-bit)}.
  - and: {8'b0, A&B}.
  - xor: {8'b0, A^B}.
  - mul: A*B, full 16-bit product. Must be staged through tinyalu_mult_pipe with registered stages, not one combinational multiply at the output.
- Non-arithmetic opcodes:
  - no_op / reserved codes: done pulses at edge k+1; result holds its previous value.
  - rst_op: result cleared to 16'h0000 at edge k+1 and done pulses. Internal state is not reset beyond that.
- result holds its value between completions; it never changes outside a done edge or reset.
- done is never high for two consecutive cycles, and never high without a preceding start sample.

Decomposition:
- tinyalu_pkg (shared with BFM/scoreboard):
  - operation_t enum with the encodings above.
  - state_t enum {IDLE, BUSY, DONE}.
  - Constants SINGLE_LAT=1, MUL_LAT_DEFAULT=3.
- Sub-module tinyalu_mult_pipe:
  - Ports: clk, reset_n, a[7:0], b[7:0], valid_in, product[15:0], valid_out.
  - Depth MUL_LATENCY-1 register stages plus input registration.
  - valid_out aligns with the counter reaching 0.

Test Plan:
- Reset then idle 5 cycles -> done=0, result=16'h0000 throughout.
- add_op A=8'hFF B=8'hFF, start at edge k -> done only in cycle after edge k+1, result=16'h01FE; and_op 8'hF0&8'h3C -> 16'h0030; xor_op 8'hF0^8'h3C -> 16'h00CC.
- mul_op A=8'hFF B=8'hFF, MUL_LATENCY=3 -> done after edge k+3, result=16'hFE01. Changing A/B to 8'h00 during BUSY leaves the result unchanged.
- no_op after add of 8'h02+8'h03 -> done after edge k+1, result stays 16'h0005; rst_op -> done pulse, result=16'h0000.
- start held high through done: add 1+1 then mul 8'h10*8'h10 -> second op begins at edge k+3, done pulses are separated by at least one low cycle, results 16'h0002 then 16'h0100.
- reset_n pulsed low at edge k+1 of a mul -> done/result go 0 asynchronously, no done after release, next add 8'h01+8'h01 returns 16'h0002 normally.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: opcode and state encodings shared by the ALU, BFM and scoreboard
package tinyalu_pkg;
  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int SINGLE_LAT = 1;
  localparam int MUL_LAT_DEFAULT = 3;
endpackage

// File: rtl/tinyalu_mult_pipe.sv
// tinyalu_mult_pipe: registered-input multiplier with DEPTH-1 product stages
module tinyalu_mult_pipe #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        valid_in,
  output logic [15:0] product,
  output logic        valid_out
);
  logic [7:0] a_q, a_d, b_q, b_d;
  logic vi_q;
  logic [15:0] p_q [DEPTH-1];
  logic [15:0] p_d [DEPTH-1];
  logic [DEPTH-2:0] v_q, v_d;
  always_comb begin
    a_d = valid_in ? a : a_q;
    b_d = valid_in ? b : b_q;
    p_d[0] = 16'(a_q) * 16'(b_q);
    v_d[0] = vi_q;
    for (int i = 1; i < DEPTH - 1; i++) begin
      p_d[i] = p_q[i-1];
      v_d[i] = v_q[i-1];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      vi_q <= 1'b0;
      v_q  <= '0;
      for (int i = 0; i < DEPTH - 1; i++) p_q[i] <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      vi_q <= valid_in;
      v_q  <= v_d;
      for (int i = 0; i < DEPTH - 1; i++) p_q[i] <= p_d[i];
    end
  end
  assign product   = p_q[DEPTH-2];
  assign valid_out = v_q[DEPTH-2];
endmodule

// File: rtl/tinyalu_core.sv
// tinyalu_core: start/done responder running single-cycle ops and a pipelined multiply
module tinyalu_core
  import tinyalu_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);
  state_t state_q, state_d;
  logic [2:0] op_q, op_d, cnt_q, cnt_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [15:0] res_q, res_d, mul_p;
  logic done_q, go, fin, mul_v;
  tinyalu_mult_pipe #(.DEPTH(MUL_LATENCY)) u_mul (
    .clk(clk), .reset_n(reset_n), .a(A), .b(B), .valid_in(go && op == mul_op),
    .product(mul_p), .valid_out(mul_v)
  );
  always_comb begin
    go = state_q == IDLE && start;
    fin = state_q == BUSY && cnt_q == 3'd0 && (op_q != mul_op || mul_v);
    state_d = go ? BUSY : fin ? DONE : state_q == DONE ? IDLE : state_q;
    op_d = go ? op : op_q;
    a_d = go ? A : a_q;
    b_d = go ? B : b_q;
    cnt_d = go ? (op == mul_op ? 3'(MUL_LATENCY - 1) : 3'(SINGLE_LAT - 1))
          : (state_q == BUSY && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
    res_d = !fin              ? res_q
          : op_q == add_op    ? {7'b0, ({1'b0, a_q} + {1'b0, b_q})}
          : op_q == and_op    ? {8'b0, a_q & b_q}
          : op_q == xor_op    ? {8'b0, a_q ^ b_q}
          : op_q == mul_op    ? mul_p
          : op_q == rst_op    ? 16'h0000
          : res_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= fin;
    end
  end
  assign done   = done_q;
  assign result = res_q;
endmodule

// File: tb/tb_tinyalu_core.sv
// tb_tinyalu_core: directed start/done sequences checked against a result scoreboard
module tb_tinyalu_core;
  import tinyalu_pkg::*;
  logic clk = 0, reset_n = 0, start = 0;
  logic [7:0] A = 0, B = 0;
  logic [2:0] op = 0;
  logic done;
  logic [15:0] result;
  logic prev_done = 0;
  logic [15:0] sb [$];
  int total = 0, passed = 0;
  tinyalu_core #(.MUL_LATENCY(3)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op),
    .start(start), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  always @(negedge clk) begin
    if (done) begin
      chk("done_twice", {31'b0, prev_done}, 32'd0);
      if (sb.size() == 0) chk("spurious_done", {31'b0, done}, 32'd0);
      else chk("result", {16'b0, result}, {16'b0, sb.pop_front()});
    end
    prev_done <= done;
  end
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] e, input int lat);
    @(negedge clk);
    A = a; B = b; op = o; start = 1;
    sb.push_back(e);
    @(posedge clk);
    #1 A = 0; B = 0; op = xor_op;
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      chk(i < lat ? "early_done" : "done_lat", {31'b0, done}, i < lat ? 32'd0 : 32'd1);
    end
    start = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", {16'b0, result}, 32'd0);
    end
    do_op(add_op, 8'hFF, 8'hFF, 16'h01FE, 1);
    do_op(and_op, 8'hF0, 8'h3C, 16'h0030, 1);
    do_op(xor_op, 8'hF0, 8'h3C, 16'h00CC, 1);
    do_op(mul_op, 8'hFF, 8'hFF, 16'hFE01, 3);
    do_op(add_op, 8'h02, 8'h03, 16'h0005, 1);
    do_op(no_op, 8'h09, 8'h09, 16'h0005, 1);
    do_op(3'b101, 8'h07, 8'h01, 16'h0005, 1);
    do_op(3'b110, 8'h07, 8'h01, 16'h0005, 1);
    do_op(rst_op, 8'h33, 8'h44, 16'h0000, 1);
    @(negedge clk);
    A = 1; B = 1; op = add_op; start = 1;
    sb.push_back(16'h0002);
    @(posedge clk);
    @(negedge clk);
    chk("hold_busy", {31'b0, done}, 32'd0);
    @(negedge clk);
    chk("hold_done1", {31'b0, done}, 32'd1);
    A = 8'h10; B = 8'h10; op = mul_op;
    sb.push_back(16'h0100);
    @(negedge clk);
    chk("hold_gap", {31'b0, done}, 32'd0);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      chk(i < 3 ? "hold_early" : "hold_done2", {31'b0, done}, i < 3 ? 32'd0 : 32'd1);
    end
    start = 0;
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; op = mul_op; start = 1;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 0; start = 0;
    #1 chk("async_done", {31'b0, done}, 32'd0);
    chk("async_result", {16'b0, result}, 32'd0);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'b0, done}, 32'd0);
    end
    do_op(add_op, 8'h01, 8'h01, 16'h0002, 1);
    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
